// File: rtl/sync_fifo_buf_pkg.sv
// Shared definitions for sync_fifo_buf: read-mode selectors and a sizing helper
// for users deriving AW from a required depth.
package sync_fifo_buf_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_buf_dp_ram.sv
// Single-clock simple dual-port RAM: write port a, registered read port b with
// enable. Storage style follows the array size.
module dp_ram_sc #(
  parameter int DW = 24,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  localparam int DEPTH = 1 << AW;

  generate
    if (DEPTH * DW >= 1024) begin : g_bram
      (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (re_b) dout_b <= mem[addr_b];
      end
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (re_b) dout_b <= mem[addr_b];
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with occupancy count, almost flags, flush, error pulses and
// a standard or first-word-fall-through read port.
module sync_fifo_buf
  import sync_fifo_buf_pkg::*;
#(
  parameter int DW     = 24,
  parameter int AW     = 9,
  parameter int FWFT   = FIFO_STD,
  parameter int AF_LVL = (1 << AW) - 4,
  parameter int AE_LVL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          almost_empty,
  output logic          underflow,
  output logic [AW:0]   count
);

  localparam bit          IS_FWFT = (FWFT != FIFO_STD);
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d, rcnt_q, rcnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          vld_q, vld_d, have_q, have_d;
  logic          mid_q, mid_d, outv_q, outv_d;
  logic [DW-1:0] out_q, out_d, ram_dout;
  logic          wr_acc, rd_acc, fetch, load_out, ram_re;

  dp_ram_sc #(.DW(DW), .AW(AW)) u_ram (
    .clk    (clk),
    .we_a   (wr_acc),
    .addr_a (wptr_q),
    .din_a  (wr_data),
    .re_b   (ram_re),
    .addr_b (rptr_q),
    .dout_b (ram_dout)
  );

  // FWFT path: RAM -> RAM read register (mid) -> output register. rcnt counts
  // words still in RAM; count covers RAM plus both prefetch stages.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    load_out = IS_FWFT & mid_q & (~outv_q | rd_acc);
    fetch    = IS_FWFT & (rcnt_q != '0) & (~mid_q | load_out);
    ram_re   = IS_FWFT ? fetch : rd_acc;

    wptr_d   = wptr_q + AW'(wr_acc);
    rptr_d   = rptr_q + AW'(ram_re);
    count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    rcnt_d   = rcnt_q + (AW+1)'(wr_acc) - (AW+1)'(fetch);
    mid_d    = fetch | (mid_q & ~load_out);
    outv_d   = load_out | (outv_q & ~rd_acc);
    out_d    = load_out ? ram_dout : out_q;
    have_d   = have_q | rd_acc;
    vld_d    = IS_FWFT ? outv_d : rd_acc;

    full_d   = (count_d == DEPTH_C);
    empty_d  = IS_FWFT ? ~outv_d : (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    ovf_d    = wr_en & full_q;
    udf_d    = rd_en & empty_q;

    if (clr) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      rcnt_d   = '0;
      mid_d    = 1'b0;
      outv_d   = 1'b0;
      out_d    = '0;
      have_d   = 1'b0;
      vld_d    = 1'b0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      afull_d  = 1'b0;
      aempty_d = 1'b1;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rcnt_q   <= '0;
      mid_q    <= 1'b0;
      outv_q   <= 1'b0;
      out_q    <= '0;
      have_q   <= 1'b0;
      vld_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rcnt_q   <= rcnt_d;
      mid_q    <= mid_d;
      outv_q   <= outv_d;
      out_q    <= out_d;
      have_q   <= have_d;
      vld_q    <= vld_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Standard mode reads straight from the RAM read register, which has no
  // reset; have_q masks it to zero until a word has actually been read.
  assign rd_data      = IS_FWFT ? out_q : (have_q ? ram_dout : '0);
  assign rd_valid     = vld_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign count        = count_q;

endmodule
